// File: rtl/tis_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tis_port_arbiter
// Description : Inbound port arbiter for one core. N_REQ neighbour writers
//               (0=UP 1=DOWN 2=LEFT 3=RIGHT) compete for the core's blocking
//               source-operand read. Reads select a writer by direction (DIR),
//               round-robin (ANY) or the previous source (LAST). Writer and
//               reader both stall until a single rendezvous transfer happens.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   wr_valid   in   N_REQ          writer i holds a word (level)
//   wr_data    in   N_REQ*DATA_W   word i at [i*DATA_W +: DATA_W]
//   wr_ack     out  N_REQ          one-cycle pulse: word i consumed
//   rd_req     in   1              core requests a word (level)
//   rd_mode    in   2              0=DIR 1=ANY 2=LAST 3=DIR
//   rd_dir     in   IDX_W          source index for DIR reads
//   rd_valid   out  1              one-cycle pulse: rd_data valid
//   rd_data    out  DATA_W         last transferred word (persistent)
//   rd_src     out  IDX_W          source of last real transfer
//   last_ok    out  1              a LAST source exists since reset
//   stall_cnt  out  STALL_W        saturating wait counter of current read
// ============================================================================
module tis_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 11,
  parameter int STALL_W = 16,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        wr_valid,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        wr_ack,
  input  logic                    rd_req,
  input  logic [1:0]              rd_mode,
  input  logic [IDX_W-1:0]        rd_dir,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [IDX_W-1:0]        rd_src,
  output logic                    last_ok,
  output logic [STALL_W-1:0]      stall_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;

  localparam logic [1:0]       c_mode_any  = 2'd1;
  localparam logic [1:0]       c_mode_last = 2'd2;
  localparam logic [IDX_W-1:0] c_idx_max   = IDX_W'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t             r_state,     w_state_nxt;
  logic [DATA_W-1:0]  r_rd_data,   w_rd_data_nxt;
  logic [IDX_W-1:0]   r_rd_src,    w_rd_src_nxt;
  logic [IDX_W-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
  logic               r_last_ok,   w_last_ok_nxt;
  logic [STALL_W-1:0] r_stall_cnt, w_stall_cnt_nxt;
  logic [N_REQ-1:0]   r_ack_vec,   w_ack_vec_nxt;

  // --------------------------------------------------------------------------
  // Per-writer decode
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_word [N_REQ];
  logic [N_REQ-1:0]  w_dir_sel;   // one-hot of rd_dir (zero when out of range)
  logic [N_REQ-1:0]  w_src_sel;   // one-hot of the recorded LAST source
  logic [N_REQ-1:0]  w_upper;     // indices at or above the round-robin pointer
  logic [N_REQ-1:0]  w_win_oh;    // one-hot of the selected winner
  logic [IDX_W-1:0]  w_win;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_port
      localparam logic [IDX_W-1:0] c_idx = IDX_W'(gi);
      assign w_word[gi]    = wr_data[gi*DATA_W +: DATA_W];
      assign w_dir_sel[gi] = (rd_dir == c_idx);
      assign w_src_sel[gi] = (r_rd_src == c_idx);
      assign w_upper[gi]   = (c_idx >= r_rr_ptr);
      assign w_win_oh[gi]  = (w_win == c_idx);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // ANY-mode round robin: the lowest valid index at or above the pointer wins;
  // if none exists the search wraps and the lowest valid index overall wins.
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0] w_any_hi;
  logic [IDX_W-1:0] w_any_win;

  assign w_any_hi = wr_valid & w_upper;

  always_comb begin
    w_any_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (wr_valid[i]) begin
        w_any_win = IDX_W'(i);
      end
    end
    // The upper half takes precedence whenever it holds a candidate.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_any_hi[i]) begin
        w_any_win = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Mode decode: eligible set, winner, NIL detection
  // --------------------------------------------------------------------------
  logic             w_nil;
  logic [N_REQ-1:0] w_elig;
  logic             w_is_any;

  always_comb begin
    w_nil    = 1'b0;
    w_elig   = '0;
    w_win    = rd_dir;
    w_is_any = 1'b0;
    case (rd_mode)
      c_mode_any: begin
        w_elig   = wr_valid;
        w_win    = w_any_win;
        w_is_any = 1'b1;
      end
      c_mode_last: begin
        // Without a recorded source a LAST read completes empty-handed.
        w_nil  = ~r_last_ok;
        w_elig = r_last_ok ? (wr_valid & w_src_sel) : '0;
        w_win  = r_rd_src;
      end
      default: begin
        w_elig = wr_valid & w_dir_sel;
        w_win  = rd_dir;
      end
    endcase
  end

  logic [IDX_W-1:0] w_rr_inc;
  assign w_rr_inc = (w_win == c_idx_max) ? '0 : (w_win + IDX_W'(1));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_data_nxt   = r_rd_data;
    w_rd_src_nxt    = r_rd_src;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_last_ok_nxt   = r_last_ok;
    w_stall_cnt_nxt = r_stall_cnt;
    w_ack_vec_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          if (w_nil) begin
            w_state_nxt   = S_DONE;
            w_rd_data_nxt = '0;
          end else if (|w_elig) begin
            w_state_nxt   = S_DONE;
            w_rd_data_nxt = w_word[w_win];
            w_rd_src_nxt  = w_win;
            w_last_ok_nxt = 1'b1;
            w_ack_vec_nxt = w_win_oh;
            if (w_is_any) begin
              w_rr_ptr_nxt = w_rr_inc;
            end
          end else if (r_stall_cnt != '1) begin
            w_stall_cnt_nxt = r_stall_cnt + STALL_W'(1);
          end
        end
      end
      S_DONE: begin
        // Inputs are ignored for the single pulse cycle.
        w_state_nxt     = S_IDLE;
        w_stall_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_data   <= '0;
      r_rd_src    <= '0;
      r_rr_ptr    <= '0;
      r_last_ok   <= 1'b0;
      r_stall_cnt <= '0;
      r_ack_vec   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_src    <= w_rd_src_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_last_ok   <= w_last_ok_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_ack_vec   <= w_ack_vec_nxt;
    end
  end

  // Pulses derive from flops cleared by the async reset, so an aborted
  // transfer drops them immediately.
  assign rd_valid  = (r_state == S_DONE);
  assign wr_ack    = r_ack_vec;
  assign rd_data   = r_rd_data;
  assign rd_src    = r_rd_src;
  assign last_ok   = r_last_ok;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tis_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tis_port_arbiter
// Description : Self-checking bench for tis_port_arbiter. A transfer-level
//               reference model is advanced on every rising edge and compared
//               with the DUT on every falling edge; directed sequences add
//               literal expectations, followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tis_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 11;
  localparam int SW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  wv    = '0;
  logic [DW-1:0] wd [N];
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]  wr_ack;
  logic          rd_req  = 1'b0;
  logic [1:0]    rd_mode = 2'd0;
  logic [1:0]    rd_dir  = 2'd0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_src;
  logic          last_ok;
  logic [SW-1:0] stall_cnt;

  assign wr_data = {wd[3], wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  tis_port_arbiter #(.N_REQ(N), .DATA_W(DW), .STALL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wv),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_mode   (rd_mode),
    .rd_dir    (rd_dir),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_src    (rd_src),
    .last_ok   (last_ok),
    .stall_cnt (stall_cnt)
  );

  // --------------------------------------------------------------------------
  // Reference model: what the core and writers observe per transfer
  // --------------------------------------------------------------------------
  bit            m_pulse;
  logic [N-1:0]  m_ack;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  logic [1:0]    m_rr;
  bit            m_last_ok;
  int unsigned   m_stall;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_pulse   = 0;
    m_ack     = '0;
    m_data    = '0;
    m_src     = 2'd0;
    m_rr      = 2'd0;
    m_last_ok = 0;
    m_stall   = 0;
  endtask

  task automatic model_step();
    logic [1:0] sel;
    bit         ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_pulse) begin
      m_pulse = 0;
      m_ack   = '0;
      m_stall = 0;
      return;
    end
    if (!rd_req) return;
    ok  = 0;
    sel = 2'd0;
    if (rd_mode == 2'd1) begin
      for (int k = 0; k < N; k++) begin
        logic [1:0] idx;
        idx = m_rr + 2'(k);
        if (!ok && wv[idx]) begin
          ok  = 1;
          sel = idx;
        end
      end
    end else if (rd_mode == 2'd2) begin
      if (!m_last_ok) begin
        m_pulse = 1;
        m_data  = '0;
        m_ack   = '0;
        return;
      end
      sel = m_src;
      ok  = wv[sel];
    end else begin
      sel = rd_dir;
      ok  = wv[sel];
    end
    if (ok) begin
      m_pulse   = 1;
      m_data    = wd[sel];
      m_src     = sel;
      m_last_ok = 1;
      m_ack     = '0;
      m_ack[sel] = 1'b1;
      if (rd_mode == 2'd1) m_rr = sel + 2'd1;
    end else if (m_stall < 65535) begin
      m_stall = m_stall + 1;
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("rd_valid",  32'(rd_valid),  32'(m_pulse));
    check("wr_ack",    32'(wr_ack),    32'(m_ack));
    check("rd_data",   32'(rd_data),   32'(m_data));
    check("rd_src",    32'(rd_src),    32'(m_src));
    check("last_ok",   32'(last_ok),   32'(m_last_ok));
    check("stall_cnt", 32'(stall_cnt), m_stall);
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wd[i] = '0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;

    // Reset state
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_ack",   32'(wr_ack),   32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_rd_src",   32'(rd_src),   32'd0);
    check("rst_last_ok",  32'(last_ok),  32'd0);
    check("rst_stall",    32'(stall_cnt), 32'd0);

    // LAST straight after reset: NIL read
    for (int i = 0; i < N; i++) wd[i] = 11'(16 + i);
    wv = 4'b1111; rd_mode = 2'd2; rd_req = 1'b1;
    cycle();
    check("nil_valid",   32'(rd_valid), 32'd1);
    check("nil_data",    32'(rd_data),  32'd0);
    check("nil_ack",     32'(wr_ack),   32'd0);
    check("nil_last_ok", 32'(last_ok),  32'd0);
    rd_req = 1'b0;
    cycle();
    check("nil_pulse_end", 32'(rd_valid), 32'd0);

    // DIR read from LEFT
    wv = 4'b0100; wd[2] = 11'h155; rd_mode = 2'd0; rd_dir = 2'd2; rd_req = 1'b1;
    cycle();
    check("dir_valid", 32'(rd_valid), 32'd1);
    check("dir_data",  32'(rd_data),  32'h155);
    check("dir_src",   32'(rd_src),   32'd2);
    check("dir_ack",   32'(wr_ack),   32'b0100);
    rd_req = 1'b0; wv = '0;
    cycle();
    check("dir_valid_end", 32'(rd_valid), 32'd0);
    check("dir_ack_end",   32'(wr_ack),   32'd0);
    check("dir_data_hold", 32'(rd_data),  32'h155);

    // ANY with all writers valid: 0,1,2,3 then wrap to 0
    wv = 4'b1111; rd_mode = 2'd1; rd_req = 1'b1;
    for (int k = 0; k < N; k++) begin
      cycle();
      check("any_src", 32'(rd_src), 32'(k));
      check("any_ack", 32'(wr_ack), 32'(1 << k));
      cycle();
    end
    cycle();
    check("any_wrap_src", 32'(rd_src), 32'd0);
    rd_req = 1'b0;
    cycle();

    // Move pointer to 3, then ANY with 0011 wraps to 0
    wv = 4'b0100; rd_req = 1'b1;
    cycle();
    check("any_p_src", 32'(rd_src), 32'd2);
    rd_req = 1'b0;
    cycle();
    wv = 4'b0011; rd_req = 1'b1;
    cycle();
    check("any_wrap2_src", 32'(rd_src), 32'd0);
    check("any_wrap2_ack", 32'(wr_ack), 32'b0001);
    rd_req = 1'b0;
    cycle();
    rd_mode = 2'd2; rd_req = 1'b1;
    cycle();
    check("last_src",  32'(rd_src),  32'd0);
    check("last_ack",  32'(wr_ack),  32'b0001);
    check("last_ok_1", 32'(last_ok), 32'd1);
    rd_req = 1'b0;
    cycle();

    // DIR stall for 20 cycles, then -5 arrives on DOWN
    wv = '0; rd_mode = 2'd0; rd_dir = 2'd1; rd_req = 1'b1;
    repeat (20) cycle();
    check("stall_20",       32'(stall_cnt), 32'd20);
    check("stall_no_valid", 32'(rd_valid),  32'd0);
    wv = 4'b0010; wd[1] = 11'h7FB;
    cycle();
    check("stall_valid", 32'(rd_valid),  32'd1);
    check("stall_data",  32'(rd_data),   32'h7FB);
    check("stall_hold",  32'(stall_cnt), 32'd20);
    rd_req = 1'b0; wv = '0;
    cycle();
    check("stall_clear", 32'(stall_cnt), 32'd0);

    // Reset while in DONE aborts the pulse
    wv = 4'b1000; wd[3] = 11'h2AA; rd_dir = 2'd3; rd_req = 1'b1;
    cycle();
    check("abort_pre_valid", 32'(rd_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_valid",   32'(rd_valid), 32'd0);
    check("abort_ack",     32'(wr_ack),   32'd0);
    check("abort_last_ok", 32'(last_ok),  32'd0);
    rd_req = 1'b0; wv = '0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("post_rst_valid",   32'(rd_valid), 32'd0);
    check("post_rst_ack",     32'(wr_ack),   32'd0);
    check("post_rst_last_ok", 32'(last_ok),  32'd0);

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      if (rst_n && $urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else if (!rst_n) begin
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (m_ack[i] || $urandom_range(0, 5) == 0) begin
          wv[i] = 1'($urandom_range(0, 1));
          wd[i] = 11'($urandom);
        end
      end
      if (m_pulse || !rd_req) begin
        rd_req  = ($urandom_range(0, 2) != 0);
        rd_mode = 2'($urandom_range(0, 3));
        rd_dir  = 2'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
